// File: rtl/obi_to_wb.sv
// rtl/obi_to_wb.sv - OBI slave to Wishbone B4 classic master bridge, one transaction in flight
module obi_to_wb #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              wb_rst_i,
    // OBI slave side
    input  logic              req_i,
    output logic              gnt_o,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       wdata_i,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    // Wishbone master side
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [ADDR_W-1:0] wbm_adr_o,
    output logic [31:0]       wbm_dat_o,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i,
    input  logic [31:0]       wbm_dat_i
);

    // The counter only ever has to reach TIMEOUT_CYCLES-1; keep at least one bit so a
    // disabled timeout still yields a legal (saturating, never compared) register.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;

    logic term_err;
    logic term_ack;
    logic term_to;
    logic term_any;

    // Termination priority inside BUS: error beats ack, ack beats timeout expiry.
    assign term_err = (state_q == ST_BUS) && wbm_err_i;
    assign term_ack = (state_q == ST_BUS) && !wbm_err_i && wbm_ack_i;
    assign term_to  = (state_q == ST_BUS) && !wbm_err_i && !wbm_ack_i
                      && TIMEOUT_EN && (cnt_q == TO_LAST);
    assign term_any = term_err || term_ack || term_to;

    // State register; reset aborts any transaction without a response.
    always_ff @(posedge clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and the combinational grant.
    always_comb begin
        state_d = state_q;
        gnt_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt_o = 1'b1;
                if (req_i) begin
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                if (term_any) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Wishbone request registers: captured on grant, held stable until termination.
    always_ff @(posedge clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'b0000;
            wbm_adr_o <= '0;
            wbm_dat_o <= 32'h0;
        end else if ((state_q == ST_IDLE) && req_i) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= we_i;
            wbm_sel_o <= be_i;
            wbm_adr_o <= addr_i;
            wbm_dat_o <= wdata_i;
        end else if (term_any) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
        end
    end

    // Wait-cycle counter: cleared on grant, counts BUS cycles without a response, saturates.
    always_ff @(posedge clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else if ((state_q == ST_IDLE) && req_i) begin
            cnt_q <= '0;
        end else if ((state_q == ST_BUS) && !term_any && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // OBI response: one rvalid pulse in RESP; rdata holds afterwards, err clears.
    always_ff @(posedge clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= 32'h0;
        end else if (term_err || term_to) begin
            rvalid_o <= 1'b1;
            err_o    <= 1'b1;
            rdata_o  <= 32'h0;
        end else if (term_ack) begin
            rvalid_o <= 1'b1;
            err_o    <= 1'b0;
            rdata_o  <= wbm_we_o ? 32'h0 : wbm_dat_i;
        end else if (state_q == ST_RESP) begin
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_obi_to_wb.sv
// tb/tb_obi_to_wb.sv - randomized self-checking bench for obi_to_wb with a timing-window model
module tb_obi_to_wb;

    localparam int T      = 4;
    localparam int R_ACK  = 0;
    localparam int R_ERR  = 1;
    localparam int R_BOTH = 2;
    localparam int R_NONE = 3;

    logic        clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        gnt_o;
    logic [31:0] addr_i = '0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = '0;
    logic [31:0] wdata_i = '0;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i = 1'b0;
    logic        wbm_err_i = 1'b0;
    logic [31:0] wbm_dat_i = '0;

    obi_to_wb #(.ADDR_W(32), .TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk_i), .wb_rst_i(wb_rst_i),
        .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i), .be_i(be_i),
        .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_dat_i(wbm_dat_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_err    = 0;
    int cyc_n    = 0;
    bit drv_en   = 0;
    bit chk_en   = 0;
    bit rand_en  = 0;

    // Active transaction: granted at the edge opening cycle g, BUS cycles g..g+k, response at g+k+1.
    int          g = -100;
    int          k = 0;
    logic        t_we;
    logic [31:0] t_addr, t_wdata, t_rdat, t_rdata;
    logic [3:0]  t_be;
    int          t_d, t_type;
    logic        t_err;
    logic [31:0] hold_rdata = '0;

    // Pending OBI request held on req_i until granted.
    bit          p_valid = 0;
    logic        p_we;
    logic [31:0] p_addr, p_wdata, p_rdat;
    logic [3:0]  p_be;
    int          p_d, p_type;

    int gq[$];
    int n_gnt = 0;
    int n_rv  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic rand_pending();
        int r;
        p_we    = 1'($urandom_range(0, 1));
        p_addr  = $urandom;
        p_be    = 4'($urandom_range(0, 15));
        p_wdata = $urandom;
        p_rdat  = $urandom;
        p_d     = $urandom_range(0, 5);
        r       = $urandom_range(0, 9);
        p_type  = (r < 6) ? R_ACK : (r == 6) ? R_ERR : (r == 7) ? R_BOTH : R_NONE;
        p_valid = 1;
    endtask

    // Per-cycle stimulus: OBI master and a scheduled Wishbone slave, both driven off the model.
    task automatic drive_cycle();
        int m;
        bit busy;
        m    = cyc_n;
        busy = (m >= g) && (m <= g + k + 1);
        if (!p_valid && rand_en && ($urandom_range(0, 99) < 60)) rand_pending();
        req_i   = p_valid;
        addr_i  = p_valid ? p_addr : $urandom;
        we_i    = p_valid ? p_we : 1'($urandom_range(0, 1));
        be_i    = p_valid ? p_be : 4'($urandom_range(0, 15));
        wdata_i = p_valid ? p_wdata : $urandom;
        if (!busy && p_valid) begin
            t_we = p_we; t_addr = p_addr; t_be = p_be; t_wdata = p_wdata;
            t_rdat = p_rdat; t_d = p_d; t_type = p_type;
            g = m + 1;
            if (t_type == R_NONE || t_d > T - 1) begin
                k = T - 1; t_err = 1'b1; t_rdata = 32'h0;
            end else begin
                k = t_d;
                t_err = (t_type != R_ACK);
                t_rdata = (t_type == R_ACK && !t_we) ? t_rdat : 32'h0;
            end
            p_valid = 0;
        end
        if (m >= g && m <= g + k) begin
            if ((m - g) == t_d && t_type != R_NONE) begin
                wbm_ack_i = (t_type == R_ACK) || (t_type == R_BOTH);
                wbm_err_i = (t_type == R_ERR) || (t_type == R_BOTH);
                wbm_dat_i = t_rdat;
            end else begin
                wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = $urandom;
            end
        end else begin
            wbm_ack_i = rand_en && ($urandom_range(0, 99) < 15);
            wbm_err_i = rand_en && ($urandom_range(0, 99) < 15);
            wbm_dat_i = $urandom;
        end
    endtask

    // Cycle counter and stimulus, applied shortly after each rising edge.
    always @(posedge clk_i) begin
        cyc_n++;
        #1;
        if (drv_en) drive_cycle();
    end

    // Compare process: every cycle, outputs against the transaction's timing window.
    always @(negedge clk_i) begin
        if (chk_en) begin
            int m;
            bit in_bus, in_resp;
            m       = cyc_n;
            in_bus  = (m >= g) && (m <= g + k);
            in_resp = (m == g + k + 1);
            check("gnt", gnt_o, !(in_bus || in_resp));
            check("cyc", wbm_cyc_o, in_bus);
            check("stb", wbm_stb_o, in_bus);
            check("rvalid", rvalid_o, in_resp);
            if (in_bus) begin
                check("adr", wbm_adr_o, t_addr);
                check("we", wbm_we_o, t_we);
                check("sel", wbm_sel_o, t_be);
                check("dat_o", wbm_dat_o, t_wdata);
            end
            if (in_resp) begin
                check("err", err_o, t_err);
                check("rdata", rdata_o, t_rdata);
                hold_rdata = t_rdata;
            end else begin
                check("err_idle", err_o, 1'b0);
                check("rdata_hold", rdata_o, hold_rdata);
            end
        end
    end

    // Grant and response bookkeeping.
    always @(negedge clk_i) begin
        if (chk_en) begin
            if (req_i && gnt_o) begin
                gq.push_back(cyc_n);
                n_gnt++;
            end
            if (rvalid_o) n_rv++;
        end
    end

    task automatic wait_no_pending();
        int w;
        w = 0;
        while (p_valid && w < 100) begin
            @(negedge clk_i);
            w++;
        end
        if (p_valid) check("pending_timeout", 1, 0);
    endtask

    task automatic set_pending(input logic we, input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata, input logic [31:0] rdat,
                               input int d, input int typ);
        wait_no_pending();
        p_we = we; p_addr = addr; p_be = be; p_wdata = wdata; p_rdat = rdat;
        p_d = d; p_type = typ; p_valid = 1;
    endtask

    task automatic run_dir(input string name, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] rdat,
                           input int d, input int typ, input int exp_lat, input int exp_cycs,
                           input logic exp_err, input logic [31:0] exp_rdata);
        int w, lat, ncyc;
        set_pending(we, addr, be, wdata, rdat, d, typ);
        w = 0;
        do begin
            @(negedge clk_i);
            w++;
        end while (!(req_i && gnt_o) && w < 50);
        check({name, "_grant_seen"}, (req_i && gnt_o), 1'b1);
        lat = 0; ncyc = 0;
        while (!rvalid_o && lat < 50) begin
            @(negedge clk_i);
            lat++;
            if (wbm_cyc_o) ncyc++;
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_bus_cycles"}, ncyc, exp_cycs);
        check({name, "_err"}, err_o, exp_err);
        check({name, "_rdata"}, rdata_o, exp_rdata);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, n0, rv0;
        repeat (3) @(negedge clk_i);
        check("rst_gnt", gnt_o, 1'b1);
        check("rst_rvalid", rvalid_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_cyc", wbm_cyc_o, 1'b0);
        check("rst_stb", wbm_stb_o, 1'b0);
        check("rst_we", wbm_we_o, 1'b0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_sel", wbm_sel_o, 4'h0);
        check("rst_adr", wbm_adr_o, 32'h0);
        check("rst_dat", wbm_dat_o, 32'h0);
        wb_rst_i = 1'b0;
        @(posedge clk_i);
        #2;
        g = -100; hold_rdata = '0;
        drv_en = 1; chk_en = 1;

        run_dir("t1_read", 1'b0, 32'h0000_1000, 4'hF, 32'h0, 32'hDEADBEEF, 0, R_ACK, 2, 1, 1'b0, 32'hDEADBEEF);
        run_dir("t2_write", 1'b1, 32'hA5A5_0001, 4'b0011, 32'h1234_5678, 32'hFFFF_FFFF, 3, R_ACK, 5, 4, 1'b0, 32'h0);
        run_dir("t4_both", 1'b0, 32'h0000_2000, 4'hF, 32'h0, 32'h5555_AAAA, 1, R_BOTH, 3, 2, 1'b1, 32'h0);
        run_dir("t5_timeout", 1'b0, 32'h0000_3000, 4'hF, 32'h0, 32'h1111_2222, 0, R_NONE, 5, 4, 1'b1, 32'h0);
        run_dir("werr", 1'b1, 32'h0000_4000, 4'b1000, 32'hCAFE_F00D, 32'h0, 0, R_ERR, 2, 1, 1'b0 | 1'b1, 32'h0);

        s0 = gq.size();
        for (int i = 0; i < 4; i++) begin
            set_pending(1'b0, 32'h100 + 32'(i * 4), 4'hF, 32'h0, 32'h7000_0000 + 32'(i), 0, R_ACK);
        end
        repeat (10) @(negedge clk_i);
        for (int i = s0 + 1; i < s0 + 4; i++) begin
            check("t3_grant_period", gq[i] - gq[i - 1], 3);
        end

        rand_en = 1;
        repeat (3000) @(negedge clk_i);
        rand_en = 0;
        wait_no_pending();
        repeat (12) @(negedge clk_i);
        check("rvalid_per_grant", n_rv, n_gnt);

        n0 = n_gnt;
        set_pending(1'b0, 32'h0000_5000, 4'hF, 32'h0, 32'h0, 0, R_NONE);
        wait_no_pending();
        repeat (2) @(negedge clk_i);
        check("t6_cyc_before_rst", wbm_cyc_o, 1'b1);
        chk_en = 0; drv_en = 0;
        rv0 = n_rv;
        #2;
        wb_rst_i = 1'b1;
        #1;
        check("t6_cyc_async", wbm_cyc_o, 1'b0);
        check("t6_stb_async", wbm_stb_o, 1'b0);
        req_i = 1'b0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            check("t6_rvalid_in_rst", rvalid_o, 1'b0);
        end
        wb_rst_i = 1'b0;
        repeat (6) begin
            @(negedge clk_i);
            check("t6_rvalid_after", rvalid_o, 1'b0);
            check("t6_gnt_after", gnt_o, 1'b1);
            check("t6_cyc_after", wbm_cyc_o, 1'b0);
        end
        check("t6_granted", n0 + 1, n_gnt);
        check("t6_no_resp", n_rv, rv0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
